// File: rtl/l2_amo_seq_pkg.sv
// Shared widths, ALU opcodes, access sizes and sequencer state encoding for the
// L2 atomic-memory-operation sequencer and its ALU.
package l2_amo_seq_pkg;

  localparam int PHY_ADDR_WIDTH      = 40;
  localparam int L2_DATA_DATA_WIDTH  = 64;
  localparam int MSG_DATA_SIZE_WIDTH = 3;
  localparam int L2_AMO_ALU_OP_WIDTH = 4;

  localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_NOP  = 4'd0;
  localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_ADD  = 4'd1;
  localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_AND  = 4'd2;
  localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_OR   = 4'd3;
  localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_XOR  = 4'd4;
  localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_MAX  = 4'd5;
  localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_MAXU = 4'd6;
  localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_MIN  = 4'd7;
  localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_MINU = 4'd8;
  localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_SWAP = 4'd9;

  localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_1B = 3'd1;
  localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_2B = 3'd2;
  localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_4B = 3'd3;
  localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_8B = 3'd4;

  localparam int L2_AMO_SEQ_STATE_WIDTH = 3;
  localparam logic [L2_AMO_SEQ_STATE_WIDTH-1:0] L2_AMO_SEQ_STATE_IDLE    = 3'd0;
  localparam logic [L2_AMO_SEQ_STATE_WIDTH-1:0] L2_AMO_SEQ_STATE_RD_REQ  = 3'd1;
  localparam logic [L2_AMO_SEQ_STATE_WIDTH-1:0] L2_AMO_SEQ_STATE_RD_WAIT = 3'd2;
  localparam logic [L2_AMO_SEQ_STATE_WIDTH-1:0] L2_AMO_SEQ_STATE_EXEC    = 3'd3;
  localparam logic [L2_AMO_SEQ_STATE_WIDTH-1:0] L2_AMO_SEQ_STATE_WR      = 3'd4;
  localparam logic [L2_AMO_SEQ_STATE_WIDTH-1:0] L2_AMO_SEQ_STATE_RESP    = 3'd5;

  typedef struct packed {
    logic [L2_AMO_ALU_OP_WIDTH-1:0] op;
    logic [PHY_ADDR_WIDTH-1:0]      addr;
    logic [MSG_DATA_SIZE_WIDTH-1:0] size;
    logic [L2_DATA_DATA_WIDTH-1:0]  data;
  } amo_req_t;

  // A request is serviceable only for 1/2/4/8-byte sizes at a naturally aligned offset
  function automatic logic amo_req_ok(input logic [MSG_DATA_SIZE_WIDTH-1:0] size,
                                      input logic [2:0] off);
    logic ok;
    case (size)
      MSG_DATA_SIZE_1B: ok = 1'b1;
      MSG_DATA_SIZE_2B: ok = (off[0] == 1'b0);
      MSG_DATA_SIZE_4B: ok = (off[1:0] == 2'b00);
      MSG_DATA_SIZE_8B: ok = (off == 3'b000);
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [L2_DATA_DATA_WIDTH-1:0] swap_bytes(
      input logic [L2_DATA_DATA_WIDTH-1:0] d);
    logic [L2_DATA_DATA_WIDTH-1:0] r;
    for (int i = 0; i < L2_DATA_DATA_WIDTH / 8; i++) begin
      r[8*i +: 8] = d[L2_DATA_DATA_WIDTH-8-8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/l2_amo_seq_if.sv
// Request, data-array read/write and response channels of the AMO sequencer.
// master is the sequencer side, slave is the pipeline/array environment.
interface l2_amo_seq_if;
  import l2_amo_seq_pkg::*;

  logic                           req_val;
  logic                           req_rdy;
  logic [L2_AMO_ALU_OP_WIDTH-1:0] req_op;
  logic [PHY_ADDR_WIDTH-1:0]      req_addr;
  logic [MSG_DATA_SIZE_WIDTH-1:0] req_size;
  logic [L2_DATA_DATA_WIDTH-1:0]  req_data;
  logic                           rd_val;
  logic                           rd_rdy;
  logic [PHY_ADDR_WIDTH-1:0]      rd_addr;
  logic [L2_DATA_DATA_WIDTH-1:0]  rd_data;
  logic                           wr_val;
  logic                           wr_rdy;
  logic [PHY_ADDR_WIDTH-1:0]      wr_addr;
  logic [L2_DATA_DATA_WIDTH-1:0]  wr_data;
  logic                           resp_val;
  logic                           resp_rdy;
  logic [L2_DATA_DATA_WIDTH-1:0]  resp_data;
  logic                           resp_err;
  logic                           busy;

  modport master (
    input  req_val, req_op, req_addr, req_size, req_data, rd_rdy, rd_data, wr_rdy, resp_rdy,
    output req_rdy, rd_val, rd_addr, wr_val, wr_addr, wr_data, resp_val, resp_data, resp_err,
           busy
  );

  modport slave (
    output req_val, req_op, req_addr, req_size, req_data, rd_rdy, rd_data, wr_rdy, resp_rdy,
    input  req_rdy, rd_val, rd_addr, wr_val, wr_addr, wr_data, resp_val, resp_data, resp_err,
           busy
  );

endinterface

// File: rtl/l2_amo_seq_alu.sv
// Combinational AMO ALU: applies op to the size/offset-selected field of the line
// and merges the result back into the otherwise unchanged memory line.
module l2_amo_alu
  import l2_amo_seq_pkg::*;
#(
  parameter int SWAP_ENDIANESS = 1
) (
  input  logic [L2_AMO_ALU_OP_WIDTH-1:0] op,
  input  logic [2:0]                     address,
  input  logic [MSG_DATA_SIZE_WIDTH-1:0] size,
  input  logic [L2_DATA_DATA_WIDTH-1:0]  memory_operand,
  input  logic [L2_DATA_DATA_WIDTH-1:0]  cpu_operand,
  output logic [L2_DATA_DATA_WIDTH-1:0]  amo_result
);

  logic [63:0] mem_s, cpu_s, mask_s, mem_f_s, cpu_f_s, mem_x_s, cpu_x_s, res_s, line_s;
  logic [5:0]  shamt_s;
  logic        lt_s, ltu_s;

  // Align the addressed field to bit 0 and sign-extend it for the signed compares
  always_comb begin
    if (SWAP_ENDIANESS != 0) begin
      mem_s = swap_bytes(memory_operand);
      cpu_s = swap_bytes(cpu_operand);
    end else begin
      mem_s = memory_operand;
      cpu_s = cpu_operand;
    end
    shamt_s = {address, 3'b000};
    case (size)
      MSG_DATA_SIZE_1B: mask_s = 64'h0000_0000_0000_00ff;
      MSG_DATA_SIZE_2B: mask_s = 64'h0000_0000_0000_ffff;
      MSG_DATA_SIZE_4B: mask_s = 64'h0000_0000_ffff_ffff;
      default:          mask_s = 64'hffff_ffff_ffff_ffff;
    endcase
    mem_f_s = (mem_s >> shamt_s) & mask_s;
    cpu_f_s = (cpu_s >> shamt_s) & mask_s;
    case (size)
      MSG_DATA_SIZE_1B: begin
        mem_x_s = {{56{mem_f_s[7]}}, mem_f_s[7:0]};
        cpu_x_s = {{56{cpu_f_s[7]}}, cpu_f_s[7:0]};
      end
      MSG_DATA_SIZE_2B: begin
        mem_x_s = {{48{mem_f_s[15]}}, mem_f_s[15:0]};
        cpu_x_s = {{48{cpu_f_s[15]}}, cpu_f_s[15:0]};
      end
      MSG_DATA_SIZE_4B: begin
        mem_x_s = {{32{mem_f_s[31]}}, mem_f_s[31:0]};
        cpu_x_s = {{32{cpu_f_s[31]}}, cpu_f_s[31:0]};
      end
      default: begin
        mem_x_s = mem_f_s;
        cpu_x_s = cpu_f_s;
      end
    endcase
    lt_s  = ($signed(mem_x_s) < $signed(cpu_x_s));
    ltu_s = (mem_f_s < cpu_f_s);
  end

  // Apply the op to the field and merge it back into the untouched bytes
  always_comb begin
    case (op)
      L2_AMO_ALU_ADD:  res_s = mem_f_s + cpu_f_s;
      L2_AMO_ALU_AND:  res_s = mem_f_s & cpu_f_s;
      L2_AMO_ALU_OR:   res_s = mem_f_s | cpu_f_s;
      L2_AMO_ALU_XOR:  res_s = mem_f_s ^ cpu_f_s;
      L2_AMO_ALU_MAX:  res_s = lt_s  ? cpu_f_s : mem_f_s;
      L2_AMO_ALU_MAXU: res_s = ltu_s ? cpu_f_s : mem_f_s;
      L2_AMO_ALU_MIN:  res_s = lt_s  ? mem_f_s : cpu_f_s;
      L2_AMO_ALU_MINU: res_s = ltu_s ? mem_f_s : cpu_f_s;
      L2_AMO_ALU_SWAP: res_s = cpu_f_s;
      default:         res_s = mem_f_s;
    endcase
    line_s = (mem_s & ~(mask_s << shamt_s)) | ((res_s & mask_s) << shamt_s);
    if (SWAP_ENDIANESS != 0) begin
      amo_result = swap_bytes(line_s);
    end else begin
      amo_result = line_s;
    end
  end

endmodule

// File: rtl/l2_amo_seq.sv
// One-at-a-time L2 AMO sequencer: read line, compute via l2_amo_alu, write back,
// and return the pre-modification line (or an error for bad size/alignment).
module l2_amo_seq
  import l2_amo_seq_pkg::*;
#(
  parameter int RD_LATENCY     = 1,
  parameter int SWAP_ENDIANESS = 1
) (
  input logic          clk,
  input logic          rst_n,
  l2_amo_seq_if.master bus
);

  localparam int CNT_W = $clog2(RD_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [L2_AMO_SEQ_STATE_WIDTH-1:0] state_q, state_nxt_s;
  amo_req_t                          req_q;
  logic [CNT_W-1:0]                  cnt_q;
  logic [L2_DATA_DATA_WIDTH-1:0]     mem_q, wr_q, alu_res_s;
  logic                              err_q, req_ok_s;
  logic                              rd_val_q, wr_val_q, resp_val_q, busy_q;

  assign req_ok_s = amo_req_ok(bus.req_size, bus.req_addr[2:0]);

  // Next-state selection
  always_comb begin
    state_nxt_s = state_q;
    case (state_q)
      L2_AMO_SEQ_STATE_IDLE: begin
        if (bus.req_val) begin
          state_nxt_s = req_ok_s ? L2_AMO_SEQ_STATE_RD_REQ : L2_AMO_SEQ_STATE_RESP;
        end else begin
          state_nxt_s = L2_AMO_SEQ_STATE_IDLE;
        end
      end
      L2_AMO_SEQ_STATE_RD_REQ: begin
        if (bus.rd_rdy) begin
          state_nxt_s = L2_AMO_SEQ_STATE_RD_WAIT;
        end else begin
          state_nxt_s = L2_AMO_SEQ_STATE_RD_REQ;
        end
      end
      L2_AMO_SEQ_STATE_RD_WAIT: begin
        if (cnt_q == CNT_ONE) begin
          state_nxt_s = L2_AMO_SEQ_STATE_EXEC;
        end else begin
          state_nxt_s = L2_AMO_SEQ_STATE_RD_WAIT;
        end
      end
      L2_AMO_SEQ_STATE_EXEC: begin
        if (req_q.op == L2_AMO_ALU_NOP) begin
          state_nxt_s = L2_AMO_SEQ_STATE_RESP;
        end else begin
          state_nxt_s = L2_AMO_SEQ_STATE_WR;
        end
      end
      L2_AMO_SEQ_STATE_WR: begin
        if (bus.wr_rdy) begin
          state_nxt_s = L2_AMO_SEQ_STATE_RESP;
        end else begin
          state_nxt_s = L2_AMO_SEQ_STATE_WR;
        end
      end
      L2_AMO_SEQ_STATE_RESP: begin
        if (bus.resp_rdy) begin
          state_nxt_s = L2_AMO_SEQ_STATE_IDLE;
        end else begin
          state_nxt_s = L2_AMO_SEQ_STATE_RESP;
        end
      end
      default: state_nxt_s = L2_AMO_SEQ_STATE_IDLE;
    endcase
  end

  // State register; valids are decoded from the next state so they leave a flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= L2_AMO_SEQ_STATE_IDLE;
      rd_val_q   <= 1'b0;
      wr_val_q   <= 1'b0;
      resp_val_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_nxt_s;
      rd_val_q   <= (state_nxt_s == L2_AMO_SEQ_STATE_RD_REQ);
      wr_val_q   <= (state_nxt_s == L2_AMO_SEQ_STATE_WR);
      resp_val_q <= (state_nxt_s == L2_AMO_SEQ_STATE_RESP);
      busy_q     <= (state_nxt_s != L2_AMO_SEQ_STATE_IDLE);
    end
  end

  // Request latch, read-latency counter, captured line and ALU result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
      cnt_q <= {CNT_W{1'b0}};
      mem_q <= {L2_DATA_DATA_WIDTH{1'b0}};
      wr_q  <= {L2_DATA_DATA_WIDTH{1'b0}};
      err_q <= 1'b0;
    end else begin
      case (state_q)
        L2_AMO_SEQ_STATE_IDLE: begin
          if (bus.req_val) begin
            req_q.op   <= bus.req_op;
            req_q.addr <= bus.req_addr;
            req_q.size <= bus.req_size;
            req_q.data <= bus.req_data;
            err_q      <= ~req_ok_s;
            // Cleared so a rejected request answers with an all-zero line
            mem_q      <= {L2_DATA_DATA_WIDTH{1'b0}};
          end
        end
        L2_AMO_SEQ_STATE_RD_REQ: begin
          if (bus.rd_rdy) begin
            cnt_q <= CNT_LOAD;
          end
        end
        L2_AMO_SEQ_STATE_RD_WAIT: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            mem_q <= bus.rd_data;
          end
        end
        L2_AMO_SEQ_STATE_EXEC: wr_q <= alu_res_s;
        L2_AMO_SEQ_STATE_RESP: begin
          if (bus.resp_rdy) begin
            err_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  l2_amo_alu #(
    .SWAP_ENDIANESS(SWAP_ENDIANESS)
  ) u_alu (
    .op            (req_q.op),
    .address       (req_q.addr[2:0]),
    .size          (req_q.size),
    .memory_operand(mem_q),
    .cpu_operand   (req_q.data),
    .amo_result    (alu_res_s)
  );

  assign bus.req_rdy   = (state_q == L2_AMO_SEQ_STATE_IDLE);
  assign bus.rd_val    = rd_val_q;
  assign bus.rd_addr   = req_q.addr;
  assign bus.wr_val    = wr_val_q;
  assign bus.wr_addr   = req_q.addr;
  assign bus.wr_data   = wr_q;
  assign bus.resp_val  = resp_val_q;
  assign bus.resp_data = mem_q;
  assign bus.resp_err  = err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_l2_amo_seq.sv
// Bench for l2_amo_seq: one instance with RD_LATENCY=1 and one with 3, both
// little-endian, driven by directed and random AMOs against a byte-level model.
module tb_l2_amo_seq;
  import l2_amo_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        req_val, rd_rdy, wr_rdy, resp_rdy;
  logic [3:0]  req_op;
  logic [39:0] req_addr;
  logic [2:0]  req_size;
  logic [63:0] req_data, rd_data;
  logic        o_req_rdy, o_rd_val, o_wr_val, o_resp_val, o_resp_err, o_busy;
  logic [39:0] o_rd_addr, o_wr_addr;
  logic [63:0] o_wr_data, o_resp_data;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  l2_amo_seq_if ifa ();
  l2_amo_seq_if ifb ();

  assign ifa.req_val = req_val & ~sel;
  assign ifb.req_val = req_val & sel;
  assign ifa.req_op = req_op;     assign ifb.req_op = req_op;
  assign ifa.req_addr = req_addr; assign ifb.req_addr = req_addr;
  assign ifa.req_size = req_size; assign ifb.req_size = req_size;
  assign ifa.req_data = req_data; assign ifb.req_data = req_data;
  assign ifa.rd_rdy = rd_rdy;     assign ifb.rd_rdy = rd_rdy;
  assign ifa.rd_data = rd_data;   assign ifb.rd_data = rd_data;
  assign ifa.wr_rdy = wr_rdy;     assign ifb.wr_rdy = wr_rdy;
  assign ifa.resp_rdy = resp_rdy; assign ifb.resp_rdy = resp_rdy;

  l2_amo_seq #(.RD_LATENCY(1), .SWAP_ENDIANESS(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  l2_amo_seq #(.RD_LATENCY(3), .SWAP_ENDIANESS(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  assign o_req_rdy   = sel ? ifb.req_rdy   : ifa.req_rdy;
  assign o_rd_val    = sel ? ifb.rd_val    : ifa.rd_val;
  assign o_rd_addr   = sel ? ifb.rd_addr   : ifa.rd_addr;
  assign o_wr_val    = sel ? ifb.wr_val    : ifa.wr_val;
  assign o_wr_addr   = sel ? ifb.wr_addr   : ifa.wr_addr;
  assign o_wr_data   = sel ? ifb.wr_data   : ifa.wr_data;
  assign o_resp_val  = sel ? ifb.resp_val  : ifa.resp_val;
  assign o_resp_data = sel ? ifb.resp_data : ifa.resp_data;
  assign o_resp_err  = sel ? ifb.resp_err  : ifa.resp_err;
  assign o_busy      = sel ? ifb.busy      : ifa.busy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int size_bytes(input logic [2:0] size);
    case (size)
      3'd1: return 1;
      3'd2: return 2;
      3'd3: return 4;
      3'd4: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic bit ref_ok(input logic [2:0] size, input logic [39:0] addr);
    int nb;
    nb = size_bytes(size);
    if (nb == 0) return 1'b0;
    return (int'(addr[2:0]) % nb) == 0;
  endfunction

  // Byte-wise little-endian reference: gather the field, operate, scatter back
  function automatic logic [63:0] ref_amo(input logic [3:0] op, input logic [39:0] addr,
                                          input logic [2:0] size, input logic [63:0] mem,
                                          input logic [63:0] cpu);
    int          nb, off, sh;
    logic [63:0] a, b, r, line;
    longint      sa, sb;
    nb = size_bytes(size);
    off = int'(addr[2:0]);
    a = 64'd0;
    b = 64'd0;
    for (int i = nb - 1; i >= 0; i--) begin
      a = (a << 8) | {56'd0, mem[8*(off+i) +: 8]};
      b = (b << 8) | {56'd0, cpu[8*(off+i) +: 8]};
    end
    sh = 64 - 8 * nb;
    sa = $signed(a << sh) >>> sh;
    sb = $signed(b << sh) >>> sh;
    case (op)
      4'd1: r = a + b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = (sa >= sb) ? a : b;
      4'd6: r = (a >= b) ? a : b;
      4'd7: r = (sa <= sb) ? a : b;
      4'd8: r = (a <= b) ? a : b;
      4'd9: r = b;
      default: r = a;
    endcase
    line = mem;
    for (int i = 0; i < nb; i++) line[8*(off+i) +: 8] = r[8*i +: 8];
    return line;
  endfunction

  function automatic bit in_win(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  // One AMO on the selected instance; expected timeline built from latency/stall rules
  task automatic run_amo(input string tag, input logic [3:0] op, input logic [39:0] addr,
                         input logic [2:0] size, input logic [63:0] mem, input logic [63:0] cpu,
                         input int s_rd, input int s_wr, input int s_rsp);
    int lat, rd_end, cap, wr_lo, wr_end, rsp_lo, rsp_end, idle_c;
    bit err, nop;
    logic [63:0] exp_wr, exp_rsp;
    lat = sel ? 3 : 1;
    err = !ref_ok(size, addr);
    nop = (op == L2_AMO_ALU_NOP);
    exp_rsp = err ? 64'd0 : mem;
    exp_wr = err ? 64'd0 : ref_amo(op, addr, size, mem, cpu);
    wr_lo = 1;
    wr_end = 0;
    if (err) begin
      rd_end = 0;
      cap = -100;
      rsp_lo = 1;
    end else begin
      rd_end = 1 + s_rd;
      cap = rd_end + lat;
      if (nop) begin
        rsp_lo = cap + 2;
      end else begin
        wr_lo = cap + 2;
        wr_end = wr_lo + s_wr;
        rsp_lo = wr_end + 1;
      end
    end
    rsp_end = rsp_lo + s_rsp;
    idle_c = rsp_end + 1;

    check({tag, " req_rdy@0"}, o_req_rdy, 1'b1);
    check({tag, " busy@0"}, o_busy, 1'b0);
    req_val = 1'b1; req_op = op; req_addr = addr; req_size = size; req_data = cpu;
    rd_rdy = (rd_end <= 0); wr_rdy = (wr_end <= 0); resp_rdy = 1'b0;
    rd_data = {$urandom, $urandom};
    for (int c = 1; c <= idle_c; c++) begin
      @(posedge clk); #1;
      req_val = 1'b0;
      check({tag, " rd_val"}, o_rd_val, in_win(c, 1, rd_end));
      check({tag, " wr_val"}, o_wr_val, in_win(c, wr_lo, wr_end));
      check({tag, " resp_val"}, o_resp_val, in_win(c, rsp_lo, rsp_end));
      check({tag, " busy"}, o_busy, (c < idle_c));
      check({tag, " req_rdy"}, o_req_rdy, (c >= idle_c));
      if (in_win(c, 1, rd_end)) check({tag, " rd_addr"}, o_rd_addr, addr);
      if (in_win(c, wr_lo, wr_end)) begin
        check({tag, " wr_data"}, o_wr_data, exp_wr);
        check({tag, " wr_addr"}, o_wr_addr, addr);
      end
      if (in_win(c, rsp_lo, rsp_end)) begin
        check({tag, " resp_data"}, o_resp_data, exp_rsp);
        check({tag, " resp_err"}, o_resp_err, err);
      end
      rd_rdy = (c >= rd_end);
      wr_rdy = (c >= wr_end);
      resp_rdy = (c >= rsp_end);
      rd_data = (c == cap) ? mem : {$urandom, $urandom};
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " req_rdy"}, o_req_rdy, 1'b1);
    check({tag, " rd_val"}, o_rd_val, 1'b0);
    check({tag, " wr_val"}, o_wr_val, 1'b0);
    check({tag, " resp_val"}, o_resp_val, 1'b0);
    check({tag, " resp_err"}, o_resp_err, 1'b0);
    check({tag, " busy"}, o_busy, 1'b0);
  endtask

  initial begin
    logic [3:0]  op;
    logic [2:0]  size;
    logic [39:0] addr;
    int          nb;
    sel = 1'b0; rst_n = 1'b0; req_val = 1'b0; req_op = 4'd0; req_addr = 40'd0;
    req_size = 3'd0; req_data = 64'd0; rd_rdy = 1'b0; wr_rdy = 1'b0; resp_rdy = 1'b0;
    rd_data = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset_a");
    check("reset_a wr_data", o_wr_data, 64'd0);
    check("reset_a resp_data", o_resp_data, 64'd0);
    sel = 1'b1; #1;
    check_idle_outputs("reset_b");
    sel = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_amo("add8", L2_AMO_ALU_ADD, 40'h0, MSG_DATA_SIZE_8B, 64'h1, 64'h2, 0, 0, 0);
    run_amo("min4", L2_AMO_ALU_MIN, 40'h4, MSG_DATA_SIZE_4B, 64'hFFFFFFFF_00000005,
            64'h00000001_00000000, 0, 0, 0);
    run_amo("minu4", L2_AMO_ALU_MINU, 40'h4, MSG_DATA_SIZE_4B, 64'hFFFFFFFF_00000005,
            64'h00000001_00000000, 0, 0, 0);
    run_amo("err2b", L2_AMO_ALU_ADD, 40'h3, MSG_DATA_SIZE_2B, 64'h1234, 64'h1, 0, 0, 0);
    run_amo("nop8", L2_AMO_ALU_NOP, 40'h8, MSG_DATA_SIZE_8B, 64'hCAFE_F00D_1234_5678,
            64'h5555, 0, 0, 0);

    sel = 1'b1;
    @(posedge clk); #1;
    run_amo("lat3_stall", L2_AMO_ALU_ADD, 40'h10, MSG_DATA_SIZE_8B, 64'h0123_4567_89AB_CDEF,
            64'h1111_1111_1111_1111, 2, 2, 2);

    // Reset pulsed while the LAT=3 instance waits for read data
    req_op = L2_AMO_ALU_ADD; req_addr = 40'h20; req_size = MSG_DATA_SIZE_8B;
    req_data = 64'h7; req_val = 1'b1; rd_rdy = 1'b1; wr_rdy = 1'b1; resp_rdy = 1'b1;
    @(posedge clk); #1;
    req_val = 1'b0;
    check("rst_mid rd_val", o_rd_val, 1'b1);
    @(posedge clk); #1;
    check("rst_mid busy_before", o_busy, 1'b1);
    rst_n = 1'b0; #1;
    check_idle_outputs("rst_mid");
    rd_data = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("rst_after");
    run_amo("xor1", L2_AMO_ALU_XOR, 40'h13, MSG_DATA_SIZE_1B, 64'h0011_2233_4455_6677,
            64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      sel = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      op = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 9) < 8) size = 3'($urandom_range(1, 4));
      else size = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(5, 7));
      addr = {8'($urandom), 32'($urandom)};
      nb = size_bytes(size);
      if (nb != 0 && $urandom_range(0, 3) != 0) addr[2:0] = addr[2:0] & ~3'(nb - 1);
      run_amo($sformatf("rand%0d", i), op, addr, size, {$urandom, $urandom},
              {$urandom, $urandom}, $urandom_range(0, 2), $urandom_range(0, 2),
              $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
